mul_div_seq: RTL and testbench

- Multi-cycle sequencer that performs unsigned 16x16 multiply and unsigned 16/16 divide.
- Time-shares one instance of the CPU's existing 16-bit add/sub unit for every iteration.
- Sits beside the ALU in the execute stage. The core issues `start` and stalls on `busy` until `done` pulses.
- Shift-add multiply and restoring divide, one iteration per clock, 16 iterations.

---
 rtl/mul_div_pkg.sv | 19 +
 rtl/add_sub_unit.sv | 22 ++
 rtl/mul_div_seq.sv | 171 +++++++++++++++++
 tb/tb_mul_div_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   OP_MUL / OP_DIV : encodings of the op input
//   ITER            : iterations per operation (equal to operand width)
//   CNT_W           : width of the iteration counter
//   state_e         : sequencer states
package mul_div_pkg;

    localparam logic        OP_MUL = 1'b0;
    localparam logic        OP_DIV = 1'b1;
    localparam int unsigned ITER   = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add_sub_unit.sv
// Shared combinational add/sub unit of the execute stage.
// Ports:
//   a, b  : operands
//   sub   : 0 = a + b, 1 = a - b (two's complement)
//   sum   : result
//   cout  : carry out; for subtraction 1 means no borrow (a >= b)
module add_sub_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff       = sub ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/mul_div_seq.sv
// Multi-cycle unsigned 16x16 multiply (shift-add) and 16/16 divide
// (restoring), one iteration per clock through a single add_sub_unit.
// Optional feature: define MUL_DIV_DIVZERO_EN to short-circuit DIV by zero
// straight to DONE and raise div_zero; otherwise div_zero is constant 0.
// Ports:
//   clk, rst   : clock (rising edge), synchronous active-high reset
//   start      : request, sampled only in IDLE
//   op         : 0 = MUL, 1 = DIV, latched on accept
//   a, b       : multiplicand/dividend, multiplier/divisor, latched on accept
//   busy       : high while iterating
//   done       : one-cycle completion pulse
//   res_hi     : MUL product[31:16] / DIV remainder
//   res_lo     : MUL product[15:0]  / DIV quotient
//   div_zero   : divide-by-zero flag
module mul_div_seq
    import mul_div_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero
);

    state_e             state_q, state_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;       // M (MUL) or D (DIV)
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;

    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic               take;
    logic [WIDTH-1:0]   acc_iter;
    logic [WIDTH-1:0]   q_iter;

    // Partial remainder after shifting in the next dividend bit.
    assign r_shift = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
    assign add_a   = (op_q == OP_DIV) ? r_shift : acc_q;

    add_sub_unit #(.WIDTH(WIDTH)) u_add_sub (
        .a    (add_a),
        .b    (m_q),
        .sub  (op_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The bit shifted out of R' counts as an extra MSB, so it forces a take.
    assign take = acc_q[WIDTH-1] | add_cout;

    always_comb begin
        acc_iter = acc_q;
        q_iter   = q_q;
        if (op_q == OP_MUL) begin
            if (q_q[0]) begin
                acc_iter = {add_cout, add_sum[WIDTH-1:1]};
                q_iter   = {add_sum[0], q_q[WIDTH-1:1]};
            end else begin
                acc_iter = {1'b0, acc_q[WIDTH-1:1]};
                q_iter   = {acc_q[0], q_q[WIDTH-1:1]};
            end
        end else begin
            acc_iter = take ? add_sum : r_shift;
            q_iter   = {q_q[WIDTH-2:0], take};
        end
    end

`ifdef MUL_DIV_DIVZERO_EN
    logic div_zero_q, div_zero_d;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        q_d      = q_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
`ifdef MUL_DIV_DIVZERO_EN
        div_zero_d = div_zero_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    acc_d   = '0;
                    cnt_d   = '0;
                    q_d     = (op == OP_DIV) ? a : b;
                    m_d     = (op == OP_DIV) ? b : a;
                    state_d = RUN;
`ifdef MUL_DIV_DIVZERO_EN
                    div_zero_d = 1'b0;
                    if (op == OP_DIV && b == '0) begin
                        state_d    = DONE;
                        res_hi_d   = a;
                        res_lo_d   = '1;
                        div_zero_d = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                acc_d = acc_iter;
                q_d   = q_iter;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d  = DONE;
                    res_hi_d = acc_iter;
                    res_lo_d = q_iter;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
`ifdef MUL_DIV_DIVZERO_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
`ifdef MUL_DIV_DIVZERO_EN
            div_zero_q <= div_zero_d;
`endif
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign res_hi = res_hi_q;
    assign res_lo = res_lo_q;
`ifdef MUL_DIV_DIVZERO_EN
    assign div_zero = div_zero_q;
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mul_div_seq.sv
module tb_mul_div_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] res_hi;
    logic [15:0] res_lo;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    mul_div_seq #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] hi;
        logic [15:0] lo;
        int          lat;   // edges from accepting edge (counted as 1) to done visible
        int          bcyc;  // cycles with busy high
        logic        dz;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op and follow it to its done pulse.
    task automatic do_op(input vec_t v, input string tag);
        int edges;
        int bc;
        @(negedge clk);
        start = 1'b1;
        op    = v.op;
        a     = v.a;
        b     = v.b;
        edges = 0;
        bc    = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            start = 1'b0;
            a     = 16'hDEAD;
            b     = 16'hBEEF;
            if (busy) bc++;
        end while (!done && edges < 40);
        check({tag, " done_seen"}, {31'd0, done}, 32'd1);
        check({tag, " latency"}, edges, v.lat);
        check({tag, " busy_cycles"}, bc, v.bcyc);
        check({tag, " res_hi"}, {16'd0, res_hi}, {16'd0, v.hi});
        check({tag, " res_lo"}, {16'd0, res_lo}, {16'd0, v.lo});
        check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, v.dz});
        @(posedge clk);
        #1;
        check({tag, " done_pulse_width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin : main
        int  npulse;
        logic [15:0] first_hi;
        logic [15:0] first_lo;
        vec_t v;

        vecs[0] = '{1'b0, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 17, 16, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 17, 16, 1'b0};
        vecs[2] = '{1'b1, 16'h03E8, 16'h0007, 16'h0006, 16'h008E, 17, 16, 1'b0};
        vecs[3] = '{1'b1, 16'h8000, 16'h0003, 16'h0002, 16'h2AAA, 17, 16, 1'b0};
`ifdef MUL_DIV_DIVZERO_EN
        vecs[4] = '{1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1, 0, 1'b1};
`else
        vecs[4] = '{1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 17, 16, 1'b0};
`endif
        vecs[5] = '{1'b0, 16'h8000, 16'h0002, 16'h0001, 16'h0000, 17, 16, 1'b0};
        vecs[6] = '{1'b1, 16'h0005, 16'h000A, 16'h0005, 16'h0000, 17, 16, 1'b0};
        vecs[7] = '{1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 17, 16, 1'b0};
        vecs[8] = '{1'b0, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 17, 16, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset res", {res_hi, res_lo}, 32'd0);
        check("reset div_zero", {31'd0, div_zero}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Start pulses while running and in DONE must be ignored.
        @(negedge clk);
        start  = 1'b1;
        op     = 1'b0;
        a      = 16'h1234;
        b      = 16'h0010;
        npulse = 0;
        first_hi = '0;
        first_lo = '0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                npulse++;
                if (npulse == 1) begin
                    first_hi = res_hi;
                    first_lo = res_lo;
                end
            end
            if (i == 5) begin
                start = 1'b1;
                op    = 1'b1;
                a     = 16'h0064;
                b     = 16'h0003;
            end else if (done) begin
                start = 1'b1;
                op    = 1'b1;
                a     = 16'h0009;
                b     = 16'h0002;
            end else begin
                start = 1'b0;
            end
        end
        check("ignore done_pulses", npulse, 1);
        check("ignore res_hi", {16'd0, first_hi}, 32'h0001);
        check("ignore res_lo", {16'd0, first_lo}, 32'h2340);
        check("ignore hold", {res_hi, res_lo}, 32'h0001_2340);
        check("ignore idle", {30'd0, busy, done}, 32'd0);

        // Reset in the middle of an operation aborts it.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        repeat (8) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("abort busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort res", {res_hi, res_lo}, 32'd0);
        npulse = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) npulse++;
        end
        check("abort no_done", npulse, 0);

        v = '{1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h000F, 17, 16, 1'b0};
        do_op(v, "post_reset_mul");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
